// File: rtl/ps2_keypad_pkg.sv
// ps2_keypad_pkg: shared scancodes, joystick bit indices and key count for the PS/2 keypad path
package ps2_keypad_pkg;
  localparam int NUM_KEYS = 20;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_FIRE1 = 8'h14;
  localparam logic [7:0] SC_FIRE2 = 8'h11;
  localparam logic [7:0] SC_STAR  = 8'h4E;
  localparam logic [7:0] SC_HASH  = 8'h55;
  localparam logic [7:0] SC_D0    = 8'h45;
  localparam logic [7:0] SC_D1    = 8'h16;
  localparam logic [7:0] SC_D2    = 8'h1E;
  localparam logic [7:0] SC_D3    = 8'h26;
  localparam logic [7:0] SC_D4    = 8'h25;
  localparam logic [7:0] SC_D5    = 8'h2E;
  localparam logic [7:0] SC_D6    = 8'h36;
  localparam logic [7:0] SC_D7    = 8'h3D;
  localparam logic [7:0] SC_D8    = 8'h3E;
  localparam logic [7:0] SC_D9    = 8'h46;
  localparam logic [7:0] SC_BTN18 = 8'h1A;
  localparam logic [7:0] SC_BTN19 = 8'h22;
  localparam logic [4:0] JB_RIGHT = 5'd0;
  localparam logic [4:0] JB_LEFT  = 5'd1;
  localparam logic [4:0] JB_DOWN  = 5'd2;
  localparam logic [4:0] JB_UP    = 5'd3;
  localparam logic [4:0] JB_FIRE1 = 5'd4;
  localparam logic [4:0] JB_FIRE2 = 5'd5;
  localparam logic [4:0] JB_STAR  = 5'd6;
  localparam logic [4:0] JB_HASH  = 5'd7;
  localparam logic [4:0] JB_D0    = 5'd8;
  localparam logic [4:0] JB_BTN18 = 5'd18;
  localparam logic [4:0] JB_BTN19 = 5'd19;
endpackage

// File: rtl/ps2_keypad_joy_decode.sv
// ps2_scancode_decode: maps {ext, code} to a joystick bit index, valid=0 for unmapped keys
// ports: ext/code in (PS/2 extended flag and scancode), valid/idx out (combinational)
module ps2_scancode_decode
  import ps2_keypad_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       valid,
  output logic [4:0] idx
);
  always_comb begin
    valid = 1'b1;
    idx = '0;
    case ({ext, code})
      {1'b1, SC_RIGHT}: idx = JB_RIGHT;
      {1'b1, SC_LEFT}:  idx = JB_LEFT;
      {1'b1, SC_DOWN}:  idx = JB_DOWN;
      {1'b1, SC_UP}:    idx = JB_UP;
      {1'b0, SC_FIRE1}: idx = JB_FIRE1;
      {1'b0, SC_FIRE2}: idx = JB_FIRE2;
      {1'b0, SC_STAR}:  idx = JB_STAR;
      {1'b0, SC_HASH}:  idx = JB_HASH;
      {1'b0, SC_D0}:    idx = JB_D0;
      {1'b0, SC_D1}:    idx = JB_D0 + 5'd1;
      {1'b0, SC_D2}:    idx = JB_D0 + 5'd2;
      {1'b0, SC_D3}:    idx = JB_D0 + 5'd3;
      {1'b0, SC_D4}:    idx = JB_D0 + 5'd4;
      {1'b0, SC_D5}:    idx = JB_D0 + 5'd5;
      {1'b0, SC_D6}:    idx = JB_D0 + 5'd6;
      {1'b0, SC_D7}:    idx = JB_D0 + 5'd7;
      {1'b0, SC_D8}:    idx = JB_D0 + 5'd8;
      {1'b0, SC_D9}:    idx = JB_D0 + 5'd9;
      {1'b0, SC_BTN18}: idx = JB_BTN18;
      {1'b0, SC_BTN19}: idx = JB_BTN19;
      default:          valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/ps2_keypad_joy.sv
// ps2_keypad_joy: turns PS/2 key events into a held-key joystick word with SOCD resolution and autofire
// ports: clk_sys/reset (async, active-high), ps2_key event word, joy_i passthrough,
//        autofire_en, clear_i (sync release-all), joy_o merged word, key_evt_o accept pulse
module ps2_keypad_joy
  import ps2_keypad_pkg::*;
#(
  parameter int AUTOFIRE_DIV = 178977,
  parameter int CNT_W = 18
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joy_i,
  input  logic        autofire_en,
  input  logic        clear_i,
  output logic [31:0] joy_o,
  output logic        key_evt_o
);
  logic tog_q, tog_d, arm_q, arm_d, last_h_q, last_h_d, last_v_q, last_v_d;
  logic phase_q, phase_d, evt_q, evt_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d, res;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] joy_q, joy_d;
  logic hit_valid, evt, press, run, wrap;
  logic [4:0] hit_idx;
  ps2_scancode_decode u_dec (
    .ext(ps2_key[8]),
    .code(ps2_key[7:0]),
    .valid(hit_valid),
    .idx(hit_idx)
  );
  // arm_q suppresses a false event on the first sample after reset
  assign evt = arm_q & (ps2_key[10] != tog_q) & hit_valid;
  assign press = evt & ps2_key[9];
  assign run = autofire_en & keys_q[JB_FIRE1];
  assign wrap = cnt_q == CNT_W'(AUTOFIRE_DIV - 1);
  always_comb begin
    tog_d = ps2_key[10];
    arm_d = 1'b1;
    keys_d = keys_q;
    if (evt) keys_d[hit_idx] = ps2_key[9];
    if (clear_i) keys_d = '0;
    // last_h: 1 = left pressed last; last_v: 1 = up pressed last
    last_h_d = clear_i ? 1'b0 : (press & hit_idx == JB_RIGHT) ? 1'b0 :
               (press & hit_idx == JB_LEFT) ? 1'b1 : last_h_q;
    last_v_d = clear_i ? 1'b0 : (press & hit_idx == JB_DOWN) ? 1'b0 :
               (press & hit_idx == JB_UP) ? 1'b1 : last_v_q;
    cnt_d = (clear_i | ~run | wrap) ? '0 : cnt_q + 1'b1;
    phase_d = (clear_i | ~run) ? 1'b0 : phase_q ^ wrap;
    res = keys_q;
    res[JB_RIGHT] = keys_q[JB_RIGHT] & ~(keys_q[JB_LEFT] & last_h_q);
    res[JB_LEFT] = keys_q[JB_LEFT] & ~(keys_q[JB_RIGHT] & ~last_h_q);
    res[JB_DOWN] = keys_q[JB_DOWN] & ~(keys_q[JB_UP] & last_v_q);
    res[JB_UP] = keys_q[JB_UP] & ~(keys_q[JB_DOWN] & ~last_v_q);
    res[JB_FIRE1] = keys_q[JB_FIRE1] & (~autofire_en | ~phase_q);
    joy_d = {12'b0, res} | joy_i;
    evt_d = evt & ~clear_i;
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tog_q <= 1'b0;
      arm_q <= 1'b0;
      keys_q <= '0;
      last_h_q <= 1'b0;
      last_v_q <= 1'b0;
      cnt_q <= '0;
      phase_q <= 1'b0;
      joy_q <= '0;
      evt_q <= 1'b0;
    end else begin
      tog_q <= tog_d;
      arm_q <= arm_d;
      keys_q <= keys_d;
      last_h_q <= last_h_d;
      last_v_q <= last_v_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      joy_q <= joy_d;
      evt_q <= evt_d;
    end
  end
  assign joy_o = joy_q;
  assign key_evt_o = evt_q;
endmodule
